data_serialize: RTL and testbench
=================================

# data_serialize

Transmit-side counterpart of the 64-slot slot-demux: latches a packed frame of `COUNT` words and replays it as a `data`/`dataChange` stream, one word per slot index, stepping the index 0..COUNT-1. The index only changes when a new word is presented, so the downstream negedge receiver captures each word exactly once. It sits between the frame producer and the slot-demux that fans the words out to the `signal1..signal64` buses.

## Interface
- `WIDTH`, 11: bits per word.
- `COUNT`, 64: words per frame; index width is fixed at 6 bits, so `COUNT` ≤ 64.
- `HOLD`, 2: clocks each word and index are held, ≥ 1.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: frame request; sampled on posedge, honoured only when `busy`=0.
- `frame_in` in WIDTH*COUNT: packed frame; word i = `frame_in[i*WIDTH +: WIDTH]`.
- `data` out WIDTH: current word, registered.
- `dataChange` out 6: current slot index, registered.
- `busy` out 1: high while a frame is being sent.
- `done` out 1: one-cycle pulse after the last word's hold period.

## Operation
- **Reset values:** `data`=0, `dataChange`=COUNT-1 (63), `busy`=0, `done`=0, state IDLE, hold counter 0, shadow frame 0.
- The idle index is COUNT-1. This matches the receiver's power-up previous-index value, so leaving reset causes no spurious write.
- **States:** IDLE and SEND.
- **IDLE:**
  - `done` is deasserted, except for the pulse cycle described under SEND.
  - If `start`=1 at a posedge: copy `frame_in` into the shadow register, set `dataChange`=0, `data`=word 0, hold counter 0, `busy`=1, and go to SEND.
- **SEND, each posedge:**
  - hold < HOLD-1: increment hold.
  - hold = HOLD-1 and index < COUNT-1: index+1, `data`=next word from the shadow register, hold=0.
  - hold = HOLD-1 and index = COUNT-1: go to IDLE, `busy`=0, `done`=1 for one cycle. `data` and `dataChange` keep the last word and index COUNT-1.
- `start` is ignored while `busy`=1. It is level-sampled, so `start` held high produces back-to-back frames.
- `frame_in` changes after acceptance do not affect the frame in flight; only the shadow register is read.
- `data` and `dataChange` always update on the same posedge; `data` never changes while the index is held.
- **Index wrap:** COUNT-1 → 0 at the start of the next frame. This is a real change, so the receiver writes slot 0.
- **Reset mid-frame:** all state returns to reset values immediately (asynchronous). `dataChange` jumps to COUNT-1 with `data`=0, so the receiver may write 0 into the last slot. This is accepted behaviour; the frame is lost and no `done` is issued.
- **Arithmetic:** the index counter is 6 bits and compared against COUNT-1, never relying on natural wrap. The hold counter is sized as clog2(HOLD)+1.

## Timing
- Start accepted at posedge t → at t: `dataChange`=0, `data`=word 0, `busy`=1 (1-cycle latency from the sampled `start`).
- Word k is presented from posedge t+k*HOLD through t+(k+1)*HOLD-1.
- Posedge t+COUNT*HOLD: `busy`→0, `done`→1. Posedge t+COUNT*HOLD+1: `done`→0.
- The earliest next acceptance is posedge t+COUNT*HOLD+1, so frames repeat every COUNT*HOLD+1 clocks with `start` held high.
- All outputs are stable for the whole clock high phase, so the receiver's negedge sample is always valid for HOLD ≥ 1.

## Test plan
- **Reset/idle:** assert `rst`, release with `start`=0 for 20 clocks → `dataChange`=63, `data`=0, `busy`=0, `done`=0 throughout.
- **Single frame** (HOLD=2, word i = i+100): pulse `start` → index 0..63 each held 2 clocks with `data`=100..163. `done` pulses at clock 128 after acceptance. A receiver model ends with slot i = i+100.
- **Back-to-back** (`start` held high, frame B = 2047-i after the first frame is accepted) → second frame begins exactly 129 clocks after the first. Index goes 63→0. Receiver slots all updated to 2047-i.
- **Busy/shadow:** pulse `start` again and change `frame_in` to all 0x555 at word 10 → no restart, remaining words come from the original frame, one `done` only.
- **Mid-frame reset:** assert `rst` asynchronously at word 30 → outputs immediately at reset values, no `done`. A new `start` afterwards sends a full frame from index 0.
- **HOLD=1 build:** single frame → index changes every clock, `done` at clock 64. The receiver captures all 64 words.

Source files
------------

// File: rtl/data_serialize.sv
`default_nettype none
// ============================================================================
// Module   : data_serialize
// Brief    : Latches a packed frame of COUNT words and replays it one word per
//            slot index, each word/index pair held for HOLD clocks.
// Revision : 1.0
// ============================================================================
module data_serialize #(
    parameter int WIDTH = 11,
    parameter int COUNT = 64,
    parameter int HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH*COUNT-1:0]   frame_in,
    output logic [WIDTH-1:0]         data,
    output logic [5:0]               dataChange,
    output logic                     busy,
    output logic                     done
);

    localparam int              HW        = $clog2(HOLD) + 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
    localparam logic [5:0]      IDX_LAST  = 6'(COUNT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                   state_q,  state_d;
    logic [HW-1:0]            hold_q,   hold_d;
    logic [5:0]               idx_q,    idx_d;
    logic [WIDTH-1:0]         data_q,   data_d;
    logic [WIDTH*COUNT-1:0]   shadow_q, shadow_d;
    logic                     busy_q,   busy_d;
    logic                     done_q,   done_d;
    logic [5:0]               next_idx;

    assign next_idx = idx_q + 6'd1;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shadow_d = frame_in;
                    idx_d    = 6'd0;
                    data_d   = frame_in[0 +: WIDTH];
                    hold_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_ONE;
                end else if (idx_q != IDX_LAST) begin
                    // Word and index advance together so the receiver sees one change per word
                    idx_d  = next_idx;
                    data_d = shadow_q[int'(next_idx) * WIDTH +: WIDTH];
                    hold_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Idle index is COUNT-1 so that leaving reset looks like "no change" downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            idx_q    <= IDX_LAST;
            data_q   <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign data       = data_q;
    assign dataChange = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_data_serialize.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_serialize
// Brief    : Directed self-checking bench for data_serialize (HOLD=2 and HOLD=1).
// Revision : 1.0
// ============================================================================
module tb_data_serialize;

    localparam int W = 11;
    localparam int N = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, start1;
    logic [W*N-1:0] frame_in, frame1;
    logic [W-1:0]   data, data1;
    logic [5:0]     dataChange, dataChange1;
    logic           busy, busy1, done, done1;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] rx_slot  [N];
    logic [W-1:0] rx_slot1 [N];
    logic [5:0]   rx_prev  = 6'd63;
    logic [5:0]   rx_prev1 = 6'd63;

    always #5 clk = ~clk;

    data_serialize #(.WIDTH(W), .COUNT(N), .HOLD(2)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_in(frame_in),
        .data(data), .dataChange(dataChange), .busy(busy), .done(done)
    );

    data_serialize #(.WIDTH(W), .COUNT(N), .HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .frame_in(frame1),
        .data(data1), .dataChange(dataChange1), .busy(busy1), .done(done1)
    );

    // Negedge receiver: writes a slot whenever the index changes
    always @(negedge clk) begin
        if (dataChange != rx_prev) begin
            rx_slot[dataChange] = data;
            rx_prev = dataChange;
        end
        if (dataChange1 != rx_prev1) begin
            rx_slot1[dataChange1] = data1;
            rx_prev1 = dataChange1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < N; i++) begin
            rx_slot[i]  = '0;
            rx_slot1[i] = '0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        frame_in = '0; frame1 = '0;
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if (dataChange !== 6'd63 || data !== 11'd0 || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle c=%0d: got idx=%0d data=%0d busy=%b done=%b, need 63/0/0/0",
                         c, dataChange, data, busy, done);
            end
        end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < N; i++) frame_in[i*W +: W] = 11'(i + 100);
        clear_slots();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 2*N; c++) begin
            total++;
            if (dataChange !== 6'(c/2) || data !== 11'(c/2 + 100) || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL single_word c=%0d: got idx=%0d data=%0d busy=%b done=%b, need %0d/%0d/1/0",
                         c, dataChange, data, busy, done, c/2, c/2 + 100);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || dataChange !== 6'd63 || data !== 11'd163) begin
            bad++;
            $display("FAIL single_done: got done=%b busy=%b idx=%0d data=%0d, need 1/0/63/163",
                     done, busy, dataChange, data);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done_clear: got done=%b busy=%b, need 0/0", done, busy);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (rx_slot[i] !== 11'(i + 100)) begin
                bad++;
                $display("FAIL single_rx slot%0d: got %0d need %0d", i, rx_slot[i], i + 100);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++) frame_in[i*W +: W] = 11'(i + 100);
        start = 1'b1;
        tick();
        for (int i = 0; i < N; i++) frame_in[i*W +: W] = 11'(2047 - i);
        for (int c = 0; c < 2*N; c++) begin
            total++;
            if (dataChange !== 6'(c/2) || data !== 11'(c/2 + 100) || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_a c=%0d: got idx=%0d data=%0d busy=%b, need %0d/%0d/1",
                         c, dataChange, data, busy, c/2, c/2 + 100);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || dataChange !== 6'd63) begin
            bad++;
            $display("FAIL b2b_gap: got done=%b busy=%b idx=%0d, need 1/0/63", done, busy, dataChange);
        end
        tick();
        clear_slots();
        start = 1'b0;
        for (int c = 0; c < 2*N; c++) begin
            total++;
            if (dataChange !== 6'(c/2) || data !== 11'(2047 - c/2) || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL b2b_b c=%0d: got idx=%0d data=%0d busy=%b done=%b, need %0d/%0d/1/0",
                         c, dataChange, data, busy, done, c/2, 2047 - c/2);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done: got done=%b busy=%b, need 1/0", done, busy);
        end
        tick();
        for (int i = 0; i < N; i++) begin
            total++;
            if (rx_slot[i] !== 11'(2047 - i)) begin
                bad++;
                $display("FAIL b2b_rx slot%0d: got %0d need %0d", i, rx_slot[i], 2047 - i);
            end
        end
    endtask

    task automatic test_busy_shadow();
        int dones = 0;
        for (int i = 0; i < N; i++) frame_in[i*W +: W] = 11'(i + 100);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 2*N + 8; c++) begin
            if (c == 20) begin
                start = 1'b1;
                for (int i = 0; i < N; i++) frame_in[i*W +: W] = 11'h555;
            end
            if (c == 21) start = 1'b0;
            if (done === 1'b1) dones++;
            if (c < 2*N) begin
                total++;
                if (dataChange !== 6'(c/2) || data !== 11'(c/2 + 100) || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL shadow c=%0d: got idx=%0d data=%0d busy=%b, need %0d/%0d/1",
                             c, dataChange, data, busy, c/2, c/2 + 100);
                end
            end
            tick();
        end
        total++;
        if (dones != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL shadow_done: got dones=%0d busy=%b, need 1/0", dones, busy);
        end
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        for (int i = 0; i < N; i++) frame_in[i*W +: W] = 11'(i + 100);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        total++;
        if (dataChange !== 6'd30 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: got idx=%0d busy=%b, need 30/1", dataChange, busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if (dataChange !== 6'd63 || data !== 11'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: got idx=%0d data=%0d busy=%b done=%b, need 63/0/0/0",
                     dataChange, data, busy, done);
        end
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done === 1'b1 || busy !== 1'b0) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL mid_nodone: got events=%0d need 0", dones);
        end
        clear_slots();
        for (int i = 0; i < N; i++) frame_in[i*W +: W] = 11'(3*i + 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 2*N; c++) begin
            total++;
            if (dataChange !== 6'(c/2) || data !== 11'(3*(c/2) + 5) || busy !== 1'b1) begin
                bad++;
                $display("FAIL mid_restart c=%0d: got idx=%0d data=%0d busy=%b, need %0d/%0d/1",
                         c, dataChange, data, busy, c/2, 3*(c/2) + 5);
            end
            tick();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL mid_restart_done: got %b need 1", done);
        end
        tick();
        for (int i = 0; i < N; i++) begin
            total++;
            if (rx_slot[i] !== 11'(3*i + 5)) begin
                bad++;
                $display("FAIL mid_rx slot%0d: got %0d need %0d", i, rx_slot[i], 3*i + 5);
            end
        end
    endtask

    task automatic test_hold1();
        clear_slots();
        for (int i = 0; i < N; i++) frame1[i*W +: W] = 11'(7*i + 9);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < N; c++) begin
            total++;
            if (dataChange1 !== 6'(c) || data1 !== 11'(7*c + 9) || busy1 !== 1'b1 || done1 !== 1'b0) begin
                bad++;
                $display("FAIL hold1 c=%0d: got idx=%0d data=%0d busy=%b done=%b, need %0d/%0d/1/0",
                         c, dataChange1, data1, busy1, done1, c, 7*c + 9);
            end
            tick();
        end
        total++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || dataChange1 !== 6'd63) begin
            bad++;
            $display("FAIL hold1_done: got done=%b busy=%b idx=%0d, need 1/0/63", done1, busy1, dataChange1);
        end
        tick();
        total++;
        if (done1 !== 1'b0) begin
            bad++;
            $display("FAIL hold1_done_clear: got %b need 0", done1);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (rx_slot1[i] !== 11'(7*i + 9)) begin
                bad++;
                $display("FAIL hold1_rx slot%0d: got %0d need %0d", i, rx_slot1[i], 7*i + 9);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        repeat (3) tick();
        test_back_to_back();
        repeat (3) tick();
        test_busy_shadow();
        repeat (3) tick();
        test_mid_reset();
        repeat (3) tick();
        test_hold1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
